// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 valid/ready stream mux, explicit select or round-robin with packet lock
// One registered output stage; in_ready is combinational from the grant and the load enable.
module stream_mux_rr #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e         state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;

  logic                load;
  logic                xfer;
  logic [SEL_W-1:0]    gnt;
  logic                gnt_vld;
  logic [DATA_W-1:0]   gnt_data;
  logic                gnt_last;
  logic [NUM_CH-1:0]   rdy_vec;

  logic [SEL_W:0]      rot_amt;
  logic [2*NUM_CH-1:0] vld_dbl;
  logic [NUM_CH-1:0]   vld_rot;
  int                  rr_off;
  int                  rr_sum;
  logic                rr_vld;
  logic [SEL_W-1:0]    rr_gnt;

  assign load = !out_valid_q || out_ready;
  assign xfer = load && gnt_vld;

  // Rotate requests so bit 0 is the channel right after ptr, then take the lowest set bit.
  always_comb begin
    rot_amt = {1'b0, ptr_q} + 1'b1;
    vld_dbl = {in_valid, in_valid} >> rot_amt;
    vld_rot = vld_dbl[NUM_CH-1:0];
    rr_off  = 0;
    rr_vld  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vld_rot[i]) begin
        rr_off = i;
        rr_vld = 1'b1;
      end
    end
    rr_sum = int'(ptr_q) + 1 + rr_off;
    if (rr_sum >= NUM_CH) begin
      rr_sum = rr_sum - NUM_CH;
    end
    rr_gnt = SEL_W'(rr_sum);
  end

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (!mode) begin
      gnt = sel;
      // Out-of-range sel simply matches no channel.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i)) begin
          gnt_vld = in_valid[i];
        end
      end
    end else if (state_q == ST_LOCKED) begin
      gnt = lock_ch_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (lock_ch_q == SEL_W'(i)) begin
          gnt_vld = in_valid[i];
        end
      end
    end else begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    rdy_vec  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data   = in_data[i*DATA_W +: DATA_W];
        gnt_last   = in_last[i];
        rdy_vec[i] = xfer;
      end
    end
  end

  // No handshake is offered to producers while reset is held.
  assign in_ready = rst_n ? rdy_vec : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;

    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = gnt_data;
        out_last_d = gnt_last;
        out_ch_d   = gnt;
      end
    end

    if (!mode) begin
      state_d = ST_IDLE;
    end else if (xfer) begin
      ptr_d = gnt;
      case (state_q)
        ST_IDLE: begin
          if (!gnt_last) begin
            state_d   = ST_LOCKED;
            lock_ch_d = gnt;
          end
        end
        ST_LOCKED: begin
          if (gnt_last) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(NUM_CH - 1);
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed and randomized checks of stream_mux_rr against a behavioural model
module tb_stream_mux_rr;

  localparam int NCH = 8;
  localparam int DW  = 8;
  localparam int SW  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic [SW-1:0]     sel = '0;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH-1:0]    in_last = '0;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [SW-1:0]     out_ch;
  logic              out_ready = 1'b1;

  logic [2:0]  sel6 = '0;
  logic [5:0]  in_valid6 = '0;
  logic [5:0]  in_last6 = '0;
  logic [47:0] in_data6 = '0;
  logic [5:0]  in_ready6;
  logic        out_valid6;
  logic [7:0]  out_data6;
  logic        out_last6;
  logic [2:0]  out_ch6;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  bit          m_locked;
  int          m_lock_ch;
  bit          m_ov;
  logic [7:0]  m_od;
  bit          m_ol;
  int          m_oc;

  always #5 clk = ~clk;

  stream_mux_rr #(.NUM_CH(NCH), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.NUM_CH(6), .DATA_W(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(sel6),
    .in_valid(in_valid6), .in_last(in_last6), .in_data(in_data6), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_data(out_data6), .out_last(out_last6), .out_ch(out_ch6),
    .out_ready(1'b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = NCH - 1;
    m_locked = 1'b0;
    m_lock_ch = 0;
    m_ov = 1'b0;
    m_od = '0;
    m_ol = 1'b0;
    m_oc = 0;
  endtask

  // Which channel the rules say is granted this cycle, if any.
  task automatic model_grant(output int g, output bit gv);
    int c;
    g = 0;
    gv = 1'b0;
    if (!mode) begin
      g = int'(sel);
      if (g < NCH) gv = in_valid[g];
    end else if (m_locked) begin
      g = m_lock_ch;
      gv = in_valid[g];
    end else begin
      for (int d = 1; d <= NCH; d++) begin
        c = (m_ptr + d) % NCH;
        if (!gv && in_valid[c]) begin
          g = c;
          gv = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    int g;
    bit gv;
    bit ld;
    logic [7:0] exp_rdy;
    #1;
    model_grant(g, gv);
    ld = !m_ov || out_ready;
    exp_rdy = (ld && gv) ? 8'(1 << g) : 8'h00;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_last", out_last, m_ol);
      check("out_ch", out_ch, m_oc);
    end
    @(posedge clk);
    if (ld) begin
      m_ov = gv;
      if (gv) begin
        m_od = in_data[g*DW +: DW];
        m_ol = in_last[g];
        m_oc = g;
      end
    end
    if (!mode) begin
      m_locked = 1'b0;
    end else if (ld && gv) begin
      m_ptr = g;
      if (!m_locked && !in_last[g]) begin
        m_locked = 1'b1;
        m_lock_ch = g;
      end else if (m_locked && in_last[g]) begin
        m_locked = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_seq[10];
    model_reset();
    do_reset();

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_ch", out_ch, 0);

    // Explicit select of ch3
    mode = 1'b0; sel = 3; in_valid = 8'h08; in_last = 8'h08; out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = 8'(8'h10 + i);
    in_data[3*DW +: DW] = 8'hA5;
    #1;
    check("sel3_in_ready", in_ready, 8'h08);
    step();
    check("sel3_out_valid", out_valid, 1);
    check("sel3_out_data", out_data, 8'hA5);
    check("sel3_out_ch", out_ch, 3);

    // Out-of-range select on the 6-channel instance
    in_valid6 = 6'h3F;
    sel6 = 3'd7;
    #1;
    check("n6_sel7_in_ready", in_ready6, 6'h00);
    sel6 = 3'd5;
    #1;
    check("n6_sel5_in_ready", in_ready6, 6'h20);

    // Round-robin over single-beat packets
    do_reset();
    mode = 1'b1; in_valid = 8'hFF; in_last = 8'hFF; out_ready = 1'b1;
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    for (int k = 0; k < 10; k++) begin
      step();
      check("rr_seq_valid", out_valid, 1);
      check("rr_seq_ch", out_ch, exp_seq[k]);
    end

    // Packet lock on ch2 with a bubble, ch5 waiting throughout
    do_reset();
    mode = 1'b1; in_valid = 8'h24; in_last = 8'h20;
    step();
    check("lock_b1_ch", out_ch, 2);
    in_valid = 8'h20;
    step();
    check("lock_bubble_valid", out_valid, 0);
    in_valid = 8'h24;
    step();
    check("lock_b2_ch", out_ch, 2);
    in_last = 8'h24;
    step();
    check("lock_b3_ch", out_ch, 2);
    step();
    check("lock_after_ch", out_ch, 5);

    // Backpressure holds the register, release drains and reloads in one cycle
    do_reset();
    mode = 1'b0; sel = 1; in_valid = 8'h02; in_last = 8'h00; out_ready = 1'b1;
    in_data[1*DW +: DW] = 8'h3C;
    step();
    check("bp_load_data", out_data, 8'h3C);
    out_ready = 1'b0;
    in_data[1*DW +: DW] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_in_ready", in_ready, 8'h00);
      step();
      check("bp_hold_data", out_data, 8'h3C);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", out_valid, 1);
    check("bp_release_data", out_data, 8'h77);

    // Mode switch abandons the lock; rr resumes after the old pointer
    do_reset();
    mode = 1'b1; in_valid = 8'h10; in_last = 8'h00;
    step();
    check("ms_lock_ch", out_ch, 4);
    mode = 1'b0; sel = 1; in_valid = 8'h12;
    step();
    check("ms_sel_ch", out_ch, 1);
    mode = 1'b1; in_valid = 8'hFF; in_last = 8'hFF;
    step();
    check("ms_rr_ch", out_ch, 5);

    // Asynchronous reset mid-packet
    do_reset();
    mode = 1'b1; in_valid = 8'h08; in_last = 8'h00;
    step();
    check("ar_lock_ch", out_ch, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_ch", out_ch, 0);
    check("ar_in_ready", in_ready, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    in_valid = 8'h09;
    step();
    check("ar_first_ch", out_ch, 0);

    // Randomized traffic against the model
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel = SW'($urandom_range(0, NCH - 1));
      in_valid = 8'($urandom);
      in_last = 8'($urandom) & 8'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 stream multiplexer with a valid/ready handshake on every input and on the output. It is the sequential successor to the team's combinational select muxes.
- Two selection modes are supported:
  - explicit select, driven by the `sel` input;
  - round-robin arbitration with packet locking.
- Output is registered (one stage).
- Sits between multiple producer datapaths and a single shared consumer, such as a bus or an ALU operand port.

Parameters:
- NUM_CH, 8, number of input channels (2..16).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(NUM_CH), select/channel index width (derived; do not override).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = explicit select via sel, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_valid  input  NUM_CH  per-channel valid.
- in_last  input  NUM_CH  per-channel end-of-packet marker.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel ready (combinational).
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered data.
- out_last  output  1  registered last flag.
- out_ch  output  SEL_W  index of the channel that supplied the current beat.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - RR pointer ptr=NUM_CH-1, so channel 0 has top priority after reset.
  - Lock state=IDLE, lock_ch=0.
- Load enable: load = !out_valid || out_ready. The output register accepts a new beat whenever it is empty or is being drained in the same cycle. This gives full throughput of 1 beat/cycle.
- Transfer on input i: in_valid[i] && in_ready[i]. Transfer on output: out_valid && out_ready.
- Latency: a beat accepted at edge k appears on out_* after edge k. It is held stable until the output transfer.
- in_ready[i] = load && gnt_vld && (gnt==i). At most one in_ready bit is high per cycle. in_ready never depends on in_valid[i] of other channels except through arbitration.
- Mode 0 (explicit select):
  - gnt=sel; gnt_vld = in_valid[sel].
  - A sel value >= NUM_CH gives gnt_vld=0: no grant, no error.
  - sel may change every cycle. The lock state is ignored and stays IDLE.
- Mode 1 (round-robin), lock FSM with states IDLE and LOCKED:
  - IDLE: gnt is the first channel with in_valid set, searching ptr+1, ptr+2, ... with wrap modulo NUM_CH.
  - IDLE, on transfer with in_last=0: lock_ch=gnt, go to LOCKED.
  - IDLE, on transfer with in_last=1: stay IDLE.
  - Any RR transfer sets ptr=gnt.
  - LOCKED: gnt=lock_ch; gnt_vld = in_valid[lock_ch]. Other channels are starved until lock_ch transfers a beat with in_last=1, which returns the FSM to IDLE.
  - Bubbles (in_valid[lock_ch]=0) while LOCKED do not release the lock.
- Mode change:
  - mode is sampled every cycle.
  - Switching 1->0 forces the lock state to IDLE on the next edge, abandoning any packet lock.
  - Switching 0->1 starts arbitration from the current ptr.
  - out_* is unaffected by a mode change.
- Backpressure: while out_valid=1 and out_ready=0, all in_ready bits are 0. The registered beat, ptr and lock state hold.
- Simultaneous events: an output drain and a new accept in the same cycle replace the register contents with no bubble.
- No grant (gnt_vld=0) while load=1: out_valid goes to 0 on the next edge, or stays 0.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is dropped with no recovery.

Test Plan:
- Mode 0, NUM_CH=8, DATA_W=8, sel=3, in_valid=8'h08, in_data ch3=8'hA5, out_ready=1 -> in_ready=8'h08; next cycle out_valid=1, out_data=8'hA5, out_ch=3. Then sel=9 is impossible for SEL_W=3; with NUM_CH=6, sel=7 -> in_ready=0.
- Mode 1, all in_valid=8'hFF, in_last=8'hFF, out_ready=1 for 10 cycles -> out_ch sequence 0,1,2,3,4,5,6,7,0,1 at one beat per cycle.
- Mode 1, packet lock: ch2 sends 3 beats (last on the 3rd) with ch5 valid throughout -> out_ch=2,2,2,5. Insert a bubble on ch2 after beat 1 -> ch5 still not granted until ch2's last beat.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1, out_data=8'h3C -> out_data stable at 8'h3C, in_ready=0. Release -> drain and accept a new beat in the same cycle, no bubble.
- Mode switch mid-packet: locked on ch4, mode set to 0 with sel=1 -> next grant goes to ch1. Returning to mode 1 -> FSM in IDLE, arbitration searches from ptr+1=5.
- Async reset pulse mid-packet (between edges) -> out_valid=0, out_ch=0, in_ready=0 immediately. After release, first RR grant goes to the lowest valid channel (ch0 if valid).
